// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : trap_ctrl
//  Purpose  : Exception/interrupt sequencer between the commit point and the
//             CSR file. Handles ecall, mret and machine-timer interrupts,
//             emits one-cycle mepc/mcause/mstatus write strobes and a
//             one-cycle PC redirect, and stalls commits while busy.
//  Revision : 1.0  initial release
// ============================================================================
module trap_ctrl #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] ECALL_CAUSE = WIDTH'(11),
    parameter logic [WIDTH-1:0] TIMER_CAUSE = WIDTH'(32'h8000_0007)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_pc,
    input  logic [WIDTH-1:0] i_next_pc,
    input  logic             i_ecall,
    input  logic             i_mret,
    input  logic             i_timer_irq,
    input  logic [WIDTH-1:0] i_mtvec,
    input  logic [WIDTH-1:0] i_mstatus,
    input  logic [WIDTH-1:0] i_mepc,
    output logic             o_mepc_wen,
    output logic [WIDTH-1:0] o_mepc_wdata,
    output logic             o_mcause_wen,
    output logic [WIDTH-1:0] o_mcause_wdata,
    output logic             o_mstatus_wen,
    output logic [WIDTH-1:0] o_mstatus_wdata,
    output logic             o_redirect,
    output logic [WIDTH-1:0] o_redirect_pc,
    output logic             o_busy
);

    // mstatus field positions
    localparam int unsigned MIE_BIT  = 3;
    localparam int unsigned MPIE_BIT = 7;
    localparam int unsigned MPP_LO   = 11;
    localparam int unsigned MPP_HI   = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CAPT  = 2'd1,
        WRITE = 2'd2,
        JUMP  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             irq_pending;
    logic             cap_trap;
    logic [WIDTH-1:0] cap_mepc;
    logic [WIDTH-1:0] cap_cause;
    logic [WIDTH-1:0] cap_mstatus;
    logic [WIDTH-1:0] cap_target;

    logic             idle;
    logic             take_ecall;
    logic             take_mret;
    logic             take_irq;
    logic             accept;
    logic [WIDTH-1:0] trap_mstatus;
    logic [WIDTH-1:0] ret_mstatus;

    // Commits are only looked at in IDLE; priority ecall > mret > interrupt.
    assign idle       = (state == IDLE);
    assign take_ecall = idle & i_valid & i_ecall;
    assign take_mret  = idle & i_valid & ~i_ecall & i_mret;
    assign take_irq   = idle & i_valid & ~i_ecall & ~i_mret
                      & irq_pending & i_mstatus[MIE_BIT];
    assign accept     = take_ecall | take_mret | take_irq;

    // Trap entry stacks MIE into MPIE; return restores it. MPP is always M.
    always_comb begin
        trap_mstatus                = i_mstatus;
        trap_mstatus[MPIE_BIT]      = i_mstatus[MIE_BIT];
        trap_mstatus[MIE_BIT]       = 1'b0;
        trap_mstatus[MPP_HI:MPP_LO] = 2'b11;
        ret_mstatus                 = i_mstatus;
        ret_mstatus[MIE_BIT]        = i_mstatus[MPIE_BIT];
        ret_mstatus[MPIE_BIT]       = 1'b1;
        ret_mstatus[MPP_HI:MPP_LO]  = 2'b11;
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pending flag follows the request level, but is dropped when taken.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irq_pending <= 1'b0;
        end else begin
            irq_pending <= take_irq ? 1'b0 : i_timer_irq;
        end
    end

    // Capture everything the sequence needs at acceptance so later CSR or
    // mtvec/mepc changes cannot disturb an in-flight sequence. mret leaves
    // the mepc/mcause data at zero since they are never written.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cap_trap    <= 1'b0;
            cap_mepc    <= '0;
            cap_cause   <= '0;
            cap_mstatus <= '0;
            cap_target  <= '0;
        end else if (accept) begin
            cap_trap    <= ~take_mret;
            cap_mepc    <= take_ecall ? i_pc : (take_irq ? i_next_pc : '0);
            cap_cause   <= take_ecall ? ECALL_CAUSE : (take_irq ? TIMER_CAUSE : '0);
            cap_mstatus <= take_mret ? ret_mstatus : trap_mstatus;
            cap_target  <= take_mret ? i_mepc : i_mtvec;
        end
    end

    // Next state and outputs; all outputs are zero in IDLE.
    always_comb begin
        state_nxt       = state;
        o_busy          = 1'b0;
        o_mepc_wen      = 1'b0;
        o_mcause_wen    = 1'b0;
        o_mstatus_wen   = 1'b0;
        o_mepc_wdata    = '0;
        o_mcause_wdata  = '0;
        o_mstatus_wdata = '0;
        o_redirect      = 1'b0;
        o_redirect_pc   = '0;
        if (!idle) begin
            o_busy          = 1'b1;
            o_mepc_wdata    = cap_mepc;
            o_mcause_wdata  = cap_cause;
            o_mstatus_wdata = cap_mstatus;
        end
        case (state)
            IDLE: begin
                if (accept) state_nxt = CAPT;
            end
            CAPT: begin
                state_nxt = WRITE;
            end
            WRITE: begin
                o_mepc_wen    = cap_trap;
                o_mcause_wen  = cap_trap;
                o_mstatus_wen = 1'b1;
                state_nxt     = JUMP;
            end
            JUMP: begin
                o_redirect    = 1'b1;
                o_redirect_pc = cap_target;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trap_ctrl
//  Purpose  : Self-checking bench for trap_ctrl: directed vector table,
//             multi-cycle corner sequences and a randomized phase compared
//             against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trap_ctrl;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         valid, ecall, mret, irq;
    logic [W-1:0] pc, next_pc, mtvec, mstatus, mepc;
    logic         mepc_wen, mcause_wen, mstatus_wen, redirect, busy;
    logic [W-1:0] mepc_wd, mcause_wd, mstatus_wd, redirect_pc;

    int checks = 0;
    int errors = 0;

    trap_ctrl #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_pc(pc),
        .i_next_pc(next_pc), .i_ecall(ecall), .i_mret(mret),
        .i_timer_irq(irq), .i_mtvec(mtvec), .i_mstatus(mstatus),
        .i_mepc(mepc), .o_mepc_wen(mepc_wen), .o_mepc_wdata(mepc_wd),
        .o_mcause_wen(mcause_wen), .o_mcause_wdata(mcause_wd),
        .o_mstatus_wen(mstatus_wen), .o_mstatus_wdata(mstatus_wd),
        .o_redirect(redirect), .o_redirect_pc(redirect_pc), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic         mepc_wen, mcause_wen, mstatus_wen, redirect, busy;
        logic [W-1:0] mepc_wd, mcause_wd, mstatus_wd, redirect_pc;
    } outs_t;

    outs_t exp_q[$];   // expected outputs of each upcoming busy cycle
    logic  pend_m;

    function automatic outs_t zero_outs();
        outs_t o;
        o.mepc_wen = 0; o.mcause_wen = 0; o.mstatus_wen = 0;
        o.redirect = 0; o.busy = 0;
        o.mepc_wd = '0; o.mcause_wd = '0; o.mstatus_wd = '0; o.redirect_pc = '0;
        return o;
    endfunction

    // MPIE <- MIE, MIE <- 0, MPP <- 3
    function automatic logic [W-1:0] ms_trap(input logic [W-1:0] m);
        return (m & ~32'h0000_1888) | 32'h0000_1800 | (m[3] ? 32'h80 : 32'h0);
    endfunction

    // MIE <- MPIE, MPIE <- 1, MPP <- 3
    function automatic logic [W-1:0] ms_ret(input logic [W-1:0] m);
        return (m & ~32'h0000_1888) | 32'h0000_1880 | (m[7] ? 32'h8 : 32'h0);
    endfunction

    task automatic model_clock();
        outs_t        c;
        logic         hit, trap, took;
        logic [W-1:0] e_mepc, e_cause, e_ms, e_tgt;
        hit = 0; trap = 0; took = 0;
        e_mepc = '0; e_cause = '0; e_ms = '0; e_tgt = '0;
        if (!rst_n) begin
            exp_q.delete();
            pend_m = 0;
            return;
        end
        if (exp_q.size() != 0) begin
            exp_q.delete(0);
        end else if (valid) begin
            if (ecall) begin
                hit = 1; trap = 1; e_mepc = pc; e_cause = 32'd11;
                e_ms = ms_trap(mstatus); e_tgt = mtvec;
            end else if (mret) begin
                hit = 1; e_ms = ms_ret(mstatus); e_tgt = mepc;
            end else if (pend_m && mstatus[3]) begin
                hit = 1; trap = 1; took = 1; e_mepc = next_pc;
                e_cause = 32'h8000_0007; e_ms = ms_trap(mstatus); e_tgt = mtvec;
            end
        end
        if (hit) begin
            c = zero_outs();
            c.busy = 1; c.mepc_wd = e_mepc; c.mcause_wd = e_cause; c.mstatus_wd = e_ms;
            exp_q.push_back(c);
            c.mepc_wen = trap; c.mcause_wen = trap; c.mstatus_wen = 1;
            exp_q.push_back(c);
            c.mepc_wen = 0; c.mcause_wen = 0; c.mstatus_wen = 0;
            c.redirect = 1; c.redirect_pc = e_tgt;
            exp_q.push_back(c);
        end
        pend_m = took ? 1'b0 : irq;
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        outs_t e;
        e = (exp_q.size() != 0) ? exp_q[0] : zero_outs();
        chk1({tag, " busy"},        busy,        e.busy);
        chk1({tag, " mepc_wen"},    mepc_wen,    e.mepc_wen);
        chk1({tag, " mcause_wen"},  mcause_wen,  e.mcause_wen);
        chk1({tag, " mstatus_wen"}, mstatus_wen, e.mstatus_wen);
        chk1({tag, " redirect"},    redirect,    e.redirect);
        chkw({tag, " mepc_wd"},     mepc_wd,     e.mepc_wd);
        chkw({tag, " mcause_wd"},   mcause_wd,   e.mcause_wd);
        chkw({tag, " mstatus_wd"},  mstatus_wd,  e.mstatus_wd);
        chkw({tag, " redirect_pc"}, redirect_pc, e.redirect_pc);
    endtask

    // Compare mid-cycle, then advance one clock; returns 1 ns after the edge.
    task automatic step(input string tag);
        @(negedge clk);
        compare_all(tag);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string        name;
        logic         ecall, mret, irq;
        logic [W-1:0] pc, next_pc, mtvec, mstatus, mepc;
        logic         exp_trap;
        logic [W-1:0] exp_mepc, exp_cause, exp_ms, exp_target;
    } vec_t;

    vec_t tbl[$];

    task automatic add_vec(input string n, input logic e, input logic r, input logic q,
                           input logic [W-1:0] p, input logic [W-1:0] np,
                           input logic [W-1:0] tv, input logic [W-1:0] ms,
                           input logic [W-1:0] ep, input logic et,
                           input logic [W-1:0] xm, input logic [W-1:0] xc,
                           input logic [W-1:0] xs, input logic [W-1:0] xt);
        vec_t v;
        v.name = n; v.ecall = e; v.mret = r; v.irq = q; v.pc = p; v.next_pc = np;
        v.mtvec = tv; v.mstatus = ms; v.mepc = ep; v.exp_trap = et;
        v.exp_mepc = xm; v.exp_cause = xc; v.exp_ms = xs; v.exp_target = xt;
        tbl.push_back(v);
    endtask

    // Commit one table entry and check the full N+1..N+4 timeline.
    task automatic run_vec(input vec_t v);
        irq = v.irq; valid = 0; ecall = 0; mret = 0;
        step({v.name, " pre"});
        valid = 1; ecall = v.ecall; mret = v.mret; pc = v.pc; next_pc = v.next_pc;
        mtvec = v.mtvec; mstatus = v.mstatus; mepc = v.mepc;
        step({v.name, " commit"});
        valid = 0; ecall = 0; mret = 0;
        chk1({v.name, " N+1 busy"}, busy, 1'b1);
        chk1({v.name, " N+1 mstatus_wen"}, mstatus_wen, 1'b0);
        // Redirect target must already be frozen.
        mtvec = ~v.mtvec; mepc = ~v.mepc;
        step({v.name, " capt"});
        chk1({v.name, " N+2 mepc_wen"}, mepc_wen, v.exp_trap);
        chk1({v.name, " N+2 mcause_wen"}, mcause_wen, v.exp_trap);
        chk1({v.name, " N+2 mstatus_wen"}, mstatus_wen, 1'b1);
        chkw({v.name, " N+2 mepc_wd"}, mepc_wd, v.exp_mepc);
        chkw({v.name, " N+2 mcause_wd"}, mcause_wd, v.exp_cause);
        chkw({v.name, " N+2 mstatus_wd"}, mstatus_wd, v.exp_ms);
        step({v.name, " write"});
        chk1({v.name, " N+3 redirect"}, redirect, 1'b1);
        chkw({v.name, " N+3 redirect_pc"}, redirect_pc, v.exp_target);
        chk1({v.name, " N+3 busy"}, busy, 1'b1);
        step({v.name, " jump"});
        chk1({v.name, " N+4 busy"}, busy, 1'b0);
        chk1({v.name, " N+4 redirect"}, redirect, 1'b0);
        chkw({v.name, " N+4 mstatus_wd"}, mstatus_wd, 32'h0);
    endtask

    initial begin
        rst_n = 0; valid = 0; ecall = 0; mret = 0; irq = 0;
        pc = '0; next_pc = '0; mtvec = '0; mstatus = '0; mepc = '0;
        pend_m = 0;

        //       name        ec mr irq pc            next_pc       mtvec         mstatus  mepc          trap mepc          cause         ms       target
        add_vec("ecall",     1, 0, 0, 32'h8000_0010, 32'h8000_0014, 32'h8000_0100, 32'h8,   32'h0,        1, 32'h8000_0010, 32'd11,       32'h1880, 32'h8000_0100);
        add_vec("mret",      0, 1, 0, 32'h8000_0200, 32'h8000_0204, 32'h8000_0100, 32'h1880, 32'h8000_0014, 0, 32'h0,        32'h0,        32'h1888, 32'h8000_0014);
        add_vec("timer",     0, 0, 1, 32'h8000_001c, 32'h8000_0020, 32'h8000_0100, 32'h8,   32'h0,        1, 32'h8000_0020, 32'h8000_0007, 32'h1880, 32'h8000_0100);
        add_vec("ecall+irq", 1, 0, 1, 32'h8000_0030, 32'h8000_0034, 32'h8000_0100, 32'h8,   32'h0,        1, 32'h8000_0030, 32'd11,       32'h1880, 32'h8000_0100);
        add_vec("irq retake",0, 0, 1, 32'h8000_003c, 32'h8000_0040, 32'h8000_0100, 32'h8,   32'h0,        1, 32'h8000_0040, 32'h8000_0007, 32'h1880, 32'h8000_0100);
        add_vec("ecall mpie",1, 0, 0, 32'h0000_0400, 32'h0000_0404, 32'h0000_0800, 32'h80,  32'h0,        1, 32'h0000_0400, 32'd11,       32'h1800, 32'h0000_0800);
        add_vec("mret mpie0",0, 1, 0, 32'h0000_0500, 32'h0000_0504, 32'h0000_0800, 32'h0,   32'h0000_0440, 0, 32'h0,        32'h0,        32'h1880, 32'h0000_0440);

        // Reset state
        step("reset0");
        step("reset1");
        rst_n = 1;
        chk1("reset busy", busy, 1'b0);
        chkw("reset redirect_pc", redirect_pc, 32'h0);
        step("post reset");

        foreach (tbl[i]) run_vec(tbl[i]);

        // Interrupt masked by MIE=0 for five commits, then enabled
        irq = 1; mstatus = 32'h0; valid = 0;
        step("masked pre");
        for (int k = 0; k < 5; k++) begin
            valid = 1; pc = 32'h8000_0060 + 32'(k * 4); next_pc = pc + 4;
            step("masked commit");
            chk1("masked busy", busy, 1'b0);
            chk1("masked redirect", redirect, 1'b0);
        end
        mstatus = 32'h8; mtvec = 32'h8000_0100; next_pc = 32'h8000_0050;
        step("unmask commit");
        valid = 0;
        chk1("unmask busy", busy, 1'b1);
        step("unmask capt");
        chkw("unmask mcause_wd", mcause_wd, 32'h8000_0007);
        chk1("unmask mcause_wen", mcause_wen, 1'b1);
        step("unmask write");
        step("unmask jump");
        irq = 0;
        step("irq low");

        // Asynchronous reset in the middle of WRITE
        valid = 1; ecall = 1; pc = 32'h8000_0070; mtvec = 32'h8000_0100; mstatus = 32'h8;
        step("rst commit");
        valid = 0; ecall = 0;
        step("rst capt");
        chk1("pre-rst mstatus_wen", mstatus_wen, 1'b1);
        rst_n = 0;
        #1;
        chk1("rst busy", busy, 1'b0);
        chk1("rst mstatus_wen", mstatus_wen, 1'b0);
        chk1("rst mepc_wen", mepc_wen, 1'b0);
        chkw("rst mepc_wd", mepc_wd, 32'h0);
        exp_q.delete();
        pend_m = 0;
        step("in reset");
        rst_n = 1;
        step("after rst 1");
        chk1("after rst redirect", redirect, 1'b0);
        step("after rst 2");
        run_vec(tbl[0]);

        // Randomized phase against the model
        for (int n = 0; n < 400; n++) begin
            valid   = ($urandom_range(0, 3) != 0);
            ecall   = ($urandom_range(0, 5) == 0);
            mret    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) irq = ~irq;
            pc      = $urandom & 32'hffff_fffc;
            next_pc = pc + 4;
            mtvec   = $urandom;
            mepc    = $urandom;
            mstatus = $urandom;
            step("rand");
        end
        valid = 0; ecall = 0; mret = 0; irq = 0;
        for (int n = 0; n < 6; n++) step("drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
